// File: rtl/bit_serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package bit_serial_sub_pkg;

   localparam int unsigned SUB_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - br, bo = borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic br,
   output logic d,
   output logic bo
);

   // Difference bit and borrow-out from the classic full-subtractor equations
   always_comb begin
      d  = x ^ y ^ br;
      bo = (~x & y) | (~(x ^ y) & br);
   end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first, through
// a single full_subtractor cell. Operands enter on a valid/ready handshake and the
// result is held until the consumer accepts it.
// Optional feature: define BIT_SERIAL_SUB_OVF_EN to add the signed overflow output ovf.
module bit_serial_subtractor
   import bit_serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef BIT_SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   state_t            state;
   logic [CntW-1:0]   cnt;
   logic [WIDTH-1:0]  a_sh;
   logic [WIDTH-1:0]  b_sh;
   logic              br;
   logic              fs_d;
   logic              fs_bo;

   full_subtractor u_fs (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .br (br),
      .d  (fs_d),
      .bo (fs_bo)
   );

   // FSM, operand/result shift registers and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         br        <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef BIT_SERIAL_SUB_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  br       <= bin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= StRun;
               end
            end
            StRun: begin
               // Difference bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts
               diff <= {fs_d, diff[WIDTH-1:1]};
               br   <= fs_bo;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + CntW'(1);
               if (cnt == LastBit) begin
                  bout      <= fs_bo;
                  out_valid <= 1'b1;
                  state     <= StDone;
`ifdef BIT_SERIAL_SUB_OVF_EN
                  // Operand signs differ and result sign differs from the minuend
                  ovf       <= (a_sh[0] != b_sh[0]) && (fs_d != a_sh[0]);
`endif
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               state     <= StIdle;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Sequential counterpart to the team's combinational 4-bit ripple-carry adder: computes `a - b - bin` one bit per clock through a single full-subtractor cell, LSB first. Operands are captured on a valid/ready handshake, and the result is held until the consumer accepts it. Used where area matters more than latency, and as the subtract path paired with the adder in the arithmetic exercises.

## Interface
Parameters:
- `WIDTH`, 4, operand and difference width in bits; must be ≥ 2.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operands presented.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `bin` in 1: borrow-in.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `diff` out WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` out 1: borrow-out. High iff `a < b + bin`, unsigned.
- `ovf` out 1: signed overflow. Present only with `BIT_SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1, `out_valid`=0.
  - When `in_valid` is high, capture `a`, `b` and `bin` into shift/borrow registers, clear the bit counter, and go to RUN.
- **RUN:**
  - `in_ready`=0, `out_valid`=0.
  - Each cycle:
    - Feed bit `a[i]`, `b[i]` and the borrow register into the full subtractor.
    - Shift the difference bit into `diff` from the MSB side.
    - Register the new borrow.
    - Increment the counter.
  - After the cycle that processes bit WIDTH-1, go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `diff`, `bout` and `ovf` are stable and do not change while `out_ready`=0.
  - On `out_ready`=1, return to IDLE.
- Full-subtractor equations:
  - `d = x ^ y ^ br`
  - `bo = (~x & y) | (~(x ^ y) & br)`
- `bout` is the final registered borrow.
- `in_valid` during RUN or DONE is ignored; operands are not latched.
- Outputs keep their last value in IDLE. `out_valid`=0 marks them stale.
- Counter width is `$clog2(WIDTH)`. It never wraps; the exit condition is counter == WIDTH-1.
- Reset in any state, including mid-RUN:
  - Go to IDLE immediately and drop the partial result.
  - `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0.

## Timing
- Accept handshake at edge 0. RUN covers edges 1..WIDTH. `out_valid` rises after edge WIDTH, giving a latency of WIDTH cycles from acceptance.
- Minimum issue interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, one DONE cycle with `out_ready`=1. `in_ready` is high again the cycle after the output handshake.
- All outputs are registered. There is no combinational path from inputs to outputs, including `in_ready`.

## Configuration
- **`BIT_SERIAL_SUB_OVF_EN` defined:**
  - Port `ovf` exists.
  - `ovf` is computed at the final bit: `(a[W-1] != b[W-1]) && (diff[W-1] != a[W-1])`, treating `bin` as part of the subtrahend.
  - Registered, and held in DONE like `diff`.
- **Not defined:** no `ovf` port and no overflow logic. All other behaviour is identical.

## Structure
- Package `bit_serial_sub_pkg` holds:
  - `state_t` (IDLE/RUN/DONE enum).
  - Default width constant `SUB_WIDTH_DEFAULT = 4`.
- Sub-module `full_subtractor` with ports `x`, `y`, `br` → `d`, `bo`. Purely combinational, one instance.
- The top holds the FSM, counter, operand shift registers, result shift register and borrow register.

## Test plan
All scenarios use WIDTH=4.
- `a`=9, `b`=3, `bin`=0, `out_ready`=1 → after 4 cycles `out_valid`=1, `diff`=6, `bout`=0.
- `a`=3, `b`=9, `bin`=0 → `diff`=10, `bout`=1. `a`=0, `b`=0, `bin`=1 → `diff`=15, `bout`=1.
- With OVF_EN: `a`=8, `b`=1, `bin`=0 → `diff`=7, `ovf`=1. `a`=5, `b`=2 → `diff`=3, `ovf`=0.
- Backpressure and ignored input:
  - Hold `out_ready`=0 for 3 cycles in DONE → `diff`/`bout` unchanged, `in_ready`=0 throughout.
  - Pulse `in_valid` with new operands during RUN → result still reflects the original operands.
- Assert `rst_n`=0 at RUN bit 2 → immediately `in_ready`=1, `out_valid`=0, `diff`=0. A new transaction after release computes correctly.
- Exhaustive sweep of all 512 `{a, b, bin}` combinations, back-to-back with `out_ready`=1 → every `{bout, diff}` equals the 5-bit `a - b - bin`.
